uart_rx_cfg: RTL

- Parametrised oversampling UART receiver; successor to the fixed 8N1 receiver.
- Adds:
  - configurable data width, parity mode, oversampling ratio and stop length
  - 2-FF rx input synchroniser
  - false-start (glitch) rejection
  - parity, framing and break error flags
  - registered output word
- Sits between the pad-side rx line and the rx FIFO. Driven by the shared baud-rate tick generator (s_tick).

---
 rtl/uart_rx_cfg.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver: configurable width/parity/stop, glitch reject, error flags.
// Outputs registered; rx pin to FSM is 2 clk; no backpressure, word is valid on rx_done_tick.
module uart_rx_cfg #(
    parameter int DBIT    = 8,
    parameter int PARITY  = 0,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] dout,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_err
);

    localparam int SW = $clog2(SB_TICK) + 1;
    localparam int NW = $clog2(DBIT);
    localparam logic [SW-1:0] S_HALF = SW'(OS/2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP_ST, S_WAIT_IDLE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_sync;
    logic [SW-1:0]     r_s;
    logic [NW-1:0]     r_n;
    logic [DBIT-1:0]   r_shift;
    logic              r_p;
    logic              r_stop_ok;
    logic              r_done;
    logic [DBIT-1:0]   r_dout;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_break_err;

    logic              w_rx_s;
    logic              w_s_clr, w_s_inc, w_n_clr, w_n_inc;
    logic              w_shift_en, w_p_en, w_stop_cap, w_complete;
    logic              w_stop_ok;
    logic              w_par_err;
    logic              w_break;

    assign w_rx_s = r_sync[1];
    // With SB_TICK == OS the stop sample and completion share one tick.
    assign w_stop_ok = w_stop_cap ? w_rx_s : r_stop_ok;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (!w_rx_s) w_state_nxt = S_START;
            S_START:     if (s_tick && r_s == S_HALF)
                             w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (s_tick && r_s == S_BIT && r_n == N_LAST)
                             w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP_ST;
            S_PAR:       if (s_tick && r_s == S_BIT) w_state_nxt = S_STOP_ST;
            S_STOP_ST:   if (s_tick && r_s == S_STOP)
                             w_state_nxt = w_stop_ok ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_rx_s) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_s_clr    = 1'b0;
        w_s_inc    = 1'b0;
        w_n_clr    = 1'b0;
        w_n_inc    = 1'b0;
        w_shift_en = 1'b0;
        w_p_en     = 1'b0;
        w_stop_cap = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE:  if (!w_rx_s) w_s_clr = 1'b1;
            S_START: if (s_tick) begin
                if (r_s == S_HALF) begin
                    w_s_clr = 1'b1;
                    w_n_clr = 1'b1;
                end else begin
                    w_s_inc = 1'b1;
                end
            end
            S_DATA: if (s_tick) begin
                if (r_s == S_BIT) begin
                    w_s_clr    = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_n != N_LAST) w_n_inc = 1'b1;
                end else begin
                    w_s_inc = 1'b1;
                end
            end
            S_PAR: if (s_tick) begin
                if (r_s == S_BIT) begin
                    w_s_clr = 1'b1;
                    w_p_en  = 1'b1;
                end else begin
                    w_s_inc = 1'b1;
                end
            end
            S_STOP_ST: if (s_tick) begin
                if (r_s == S_BIT) w_stop_cap = 1'b1;
                if (r_s == S_STOP) begin
                    w_complete = 1'b1;
                    w_s_clr    = 1'b1;
                end else begin
                    w_s_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_par_err = 1'b0;
        if (PARITY == 1)      w_par_err = (^r_shift) ^ r_p;
        else if (PARITY == 2) w_par_err = ~((^r_shift) ^ r_p);
        w_break = ~w_stop_ok & (r_shift == '0) & ((PARITY == 0) | ~r_p);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync       <= 2'b11;
            r_s          <= '0;
            r_n          <= '0;
            r_shift      <= '0;
            r_p          <= 1'b0;
            r_stop_ok    <= 1'b0;
            r_done       <= 1'b0;
            r_dout       <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_err  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            if (w_s_clr)      r_s <= '0;
            else if (w_s_inc) r_s <= r_s + SW'(1);
            if (w_n_clr)      r_n <= '0;
            else if (w_n_inc) r_n <= r_n + NW'(1);
            if (w_shift_en) r_shift   <= {w_rx_s, r_shift[DBIT-1:1]};
            if (w_p_en)     r_p       <= w_rx_s;
            if (w_stop_cap) r_stop_ok <= w_rx_s;
            r_done <= w_complete;
            if (w_complete) begin
                r_dout       <= r_shift;
                r_parity_err <= w_par_err;
                r_frame_err  <= ~w_stop_ok;
                r_break_err  <= w_break;
            end
        end
    end

    assign rx_done_tick = r_done;
    assign dout         = r_dout;
    assign parity_err   = r_parity_err;
    assign frame_err    = r_frame_err;
    assign break_err    = r_break_err;

endmodule
